main_mem_responder: RTL
=======================

Name: main_mem_responder

Overview:
- Memory-side end of the cache/main-memory bank transfer protocol.
- Answers bank fill (read) and bank eviction (write-back) requests from the cache miss controller.
- Fill: acknowledges the command, then streams 512 words into the cache RAM.
- Write-back: accepts 512 words one per acknowledge. Bridges to an external fixed-latency word memory.

Parameters:
- DATA_W, 32, word width on every data bus.
- BANK_W, 9, bank index width. External address is {bank, 9-bit word index}.
- RD_LAT, 2, external read latency in cycles from ext_re to valid ext_rdata (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_rd  in  1  level; bank fill requested.
- req_wr  in  1  level; dirty-bank write-back in progress.
- req_bank  in  BANK_W  bank index; sampled at request acceptance.
- wr_data  in  DATA_W  evicted word at the cache's current read index.
- mem_wr_ack  out  1  one-cycle pulse. Acks the fill command, or acks each write-back word.
- cache_wr_en  out  1  fill word valid this cycle.
- cache_wr_addr  out  9  fill word index.
- cache_wr_data  out  DATA_W  fill word.
- cache_wr_done  out  1  high with the last fill word (index 511).
- ext_addr  out  BANK_W+9  external word address.
- ext_re  out  1  external read strobe.
- ext_we  out  1  external write strobe.
- ext_wdata  out  DATA_W  external write data.
- ext_rdata  in  DATA_W  external read data; valid exactly RD_LAT cycles after ext_re.
- ext_ready  in  1  when low, no new ext_re/ext_we may issue. Reads already in flight still return.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0. Counters cleared. In-flight read returns discarded; no cache_wr_en for them after reset release.
- States: IDLE, RD_ACK, RD_STREAM, RD_DRAIN, WR_GAP, WR_ACK, DONE.
- IDLE:
  - req_wr=1 -> latch req_bank, go WR_GAP. Write wins if req_rd and req_wr are both high.
  - else req_rd=1 -> latch bank, go RD_ACK.
- RD_ACK: mem_wr_ack=1 for exactly one cycle; issue counter=0; go RD_STREAM.
- RD_STREAM: each cycle with ext_ready=1:
  - ext_re=1, ext_addr={bank, issue_cnt}, issue_cnt++.
  - After index 511 issues, go RD_DRAIN. No ext_re while ext_ready=0.
- Read return: delay line of depth RD_LAT carries {valid, index}.
  - When a valid entry emerges: cache_wr_en=1, cache_wr_data=ext_rdata, cache_wr_addr=index.
  - cache_wr_done=1 in the same cycle when index==511.
  - The first cache_wr_en is never earlier than 2 cycles after the ack pulse. The initiator needs one cycle to enter its wait state.
- RD_DRAIN: wait until the 511 return emerges, then go DONE.
- Exactly 512 cache_wr_en pulses per fill, indices 0..511 in order. Gaps follow ext_ready.
- WR_GAP: one idle cycle so the cache RAM output settles on the new index. go WR_ACK.
- WR_ACK:
  - If ext_ready=1: ext_we=1, ext_addr={bank, wr_cnt}, ext_wdata=wr_data; mem_wr_ack=1 same cycle; wr_cnt++.
  - If wr_cnt was 511, go DONE; else go WR_GAP.
  - If ext_ready=0: hold in WR_ACK with no ack.
  - Max throughput: one word per 2 cycles.
- Counters are 9 bits. 511 is terminal; no wrap occurs within a transfer.
- DONE: outputs idle. Stay until req_rd=0 and req_wr=0, then go IDLE. Prevents re-triggering on a lingering request level.
- Request deasserted mid-transfer: ignored; transfer runs to completion.
- req_bank changes mid-transfer: ignored, since the latched copy is used.
- mem_wr_ack and cache_wr_en are never high in the same cycle.

Test Plan:
- Fill, RD_LAT=2, ext_ready=1, req_bank=5 -> one ack pulse. ext_re issues on 512 consecutive cycles at addresses 0xA00..0xBFF. cache_wr_en begins 2 cycles after the first ext_re, with indices 0..511. cache_wr_done coincides with index 511. Responder reaches DONE, then IDLE once req_rd=0.
- Write-back, req_bank=3, wr_data=index-derived pattern -> 512 acks spaced 2 cycles apart. ext_we addresses 0x600..0x7FF with matching data. Responder holds DONE while req_wr stays high, then goes IDLE.
- ext_ready held low 10 cycles mid-fill and mid-write -> no new strobes during the hold. In-flight reads still produce cache_wr_en. Totals remain 512 and order is preserved.
- req_rd and req_wr rise in the same cycle -> write-back runs; no read ack is issued until the request is re-raised after DONE.
- Async rst pulse during RD_STREAM with reads in flight -> outputs go 0 immediately. No stale cache_wr_en after release. A new fill then completes normally.
- RD_LAT=1 and RD_LAT=4 builds -> cache_wr_en lags ext_re by exactly RD_LAT cycles; done on index 511.

Source files
------------

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_responder
// Description : Memory-side end of the cache/main-memory bank transfer
//               protocol. Serves bank fills (streams 512 words from a
//               fixed-latency external memory into the cache RAM) and bank
//               write-backs (stores 512 evicted words, one per acknowledge).
// Ports       : clk, rst            - clock, async active-high reset
//               req_rd/req_wr       - fill / write-back request levels
//               req_bank            - bank index, latched on acceptance
//               wr_data             - evicted word at the cache read index
//               mem_wr_ack          - fill command ack / per-word write ack
//               cache_wr_*          - fill word write port into the cache
//               ext_*               - external word memory interface
//               busy                - responder not idle
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_responder #(
    parameter int DATA_W = 32,
    parameter int BANK_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [BANK_W-1:0]   req_bank,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                mem_wr_ack,
    output logic                cache_wr_en,
    output logic [8:0]          cache_wr_addr,
    output logic [DATA_W-1:0]   cache_wr_data,
    output logic                cache_wr_done,
    output logic [BANK_W+8:0]   ext_addr,
    output logic                ext_re,
    output logic                ext_we,
    output logic [DATA_W-1:0]   ext_wdata,
    input  logic [DATA_W-1:0]   ext_rdata,
    input  logic                ext_ready,
    output logic                busy
);

    localparam logic [8:0] c_LAST_IDX = 9'd511;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_ACK    = 3'd1,
        S_RD_STREAM = 3'd2,
        S_RD_DRAIN  = 3'd3,
        S_WR_GAP    = 3'd4,
        S_WR_ACK    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BANK_W-1:0]      r_bank;
    logic [8:0]             r_cnt;      // read issue index or write-back index

    // Read-return delay line: entry RD_LAT-1 lines up with ext_rdata.
    logic [RD_LAT-1:0]      r_pipe_vld;
    logic [8:0]             r_pipe_idx [RD_LAT];

    logic                   w_ret_vld;
    logic [8:0]             w_ret_idx;
    logic                   w_ack;
    logic                   w_re;
    logic                   w_we;
    logic [BANK_W+8:0]      w_ext_addr;
    logic [DATA_W-1:0]      w_ext_wdata;

    assign w_ret_vld = r_pipe_vld[RD_LAT-1];
    assign w_ret_idx = r_pipe_idx[RD_LAT-1];

    always_comb begin
        w_next      = r_state;
        w_ack       = 1'b0;
        w_re        = 1'b0;
        w_we        = 1'b0;
        w_ext_addr  = '0;
        w_ext_wdata = '0;
        case (r_state)
            S_IDLE: begin
                // Write-back has priority: the dirty bank must leave first.
                if (req_wr) begin
                    w_next = S_WR_GAP;
                end else if (req_rd) begin
                    w_next = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                w_ack  = 1'b1;
                w_next = S_RD_STREAM;
            end
            S_RD_STREAM: begin
                if (ext_ready) begin
                    w_re       = 1'b1;
                    w_ext_addr = {r_bank, r_cnt};
                    if (r_cnt == c_LAST_IDX) begin
                        w_next = S_RD_DRAIN;
                    end
                end
            end
            S_RD_DRAIN: begin
                if (w_ret_vld && (w_ret_idx == c_LAST_IDX)) begin
                    w_next = S_DONE;
                end
            end
            S_WR_GAP: begin
                // Lets the cache RAM output settle on the advanced index.
                w_next = S_WR_ACK;
            end
            S_WR_ACK: begin
                if (ext_ready) begin
                    w_we        = 1'b1;
                    w_ack       = 1'b1;
                    w_ext_addr  = {r_bank, r_cnt};
                    w_ext_wdata = wr_data;
                    w_next      = (r_cnt == c_LAST_IDX) ? S_DONE : S_WR_GAP;
                end
            end
            S_DONE: begin
                // Wait for both request levels to drop so a lingering level
                // does not start a second transfer.
                if (!req_rd && !req_wr) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bank  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && (req_rd || req_wr)) begin
                r_bank <= req_bank;
            end
            if ((r_state == S_IDLE) || (r_state == S_RD_ACK)) begin
                r_cnt <= '0;
            end else if (w_re || w_we) begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_re;
            r_pipe_idx[0] <= r_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    assign mem_wr_ack    = w_ack;
    assign ext_re        = w_re;
    assign ext_we        = w_we;
    assign ext_addr      = w_ext_addr;
    assign ext_wdata     = w_ext_wdata;
    assign cache_wr_en   = w_ret_vld;
    assign cache_wr_addr = w_ret_vld ? w_ret_idx : 9'd0;
    assign cache_wr_data = w_ret_vld ? ext_rdata : '0;
    assign cache_wr_done = w_ret_vld && (w_ret_idx == c_LAST_IDX);
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
